// File: rtl/c3_pool_window_buffer.sv
// -----------------------------------------------------------------------------
// c3_pool_window_buffer
//
// Sits in front of the C3 max-pooling stage. Takes the C3 conv/ReLU stream
// (all CH channels of one pixel per beat, raster order), keeps one even row in
// a line buffer and emits non-overlapping 2x2 windows, one packed word per
// channel, with a single-cycle valid one clock after the completing beat.
//
// Ports
//   clk            clock
//   rst_n          synchronous active-low reset
//   c3_in_valid    input beat qualifier
//   c3_in_sof      start of frame, only looked at when c3_in_valid=1
//   c3_in_data     pixel, channel k at [DW*k +: DW]
//   c3_reg_valid   one-cycle window valid pulse
//   c3_reg_out     windows, channel k at [4*DW*k +: 4*DW] = {TL, TR, BL, BR}
//   c3_frame_done  pulses together with the last window of a frame
// -----------------------------------------------------------------------------
module c3_pool_window_buffer #(
  parameter int IMG_W = 10,
  parameter int IMG_H = 10,
  parameter int CH    = 16,
  parameter int DW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c3_in_valid,
  input  logic                 c3_in_sof,
  input  logic [CH*DW-1:0]     c3_in_data,
  output logic                 c3_reg_valid,
  output logic [CH*4*DW-1:0]   c3_reg_out,
  output logic                 c3_frame_done
);

  localparam int PW = CH * DW;
  localparam int WW = 4 * DW;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  // Position of the beat that completes the final window; an odd trailing
  // column/row never completes a window, so it is floored away.
  localparam logic [CW-1:0] WIN_COL  = CW'((IMG_W % 2 == 0) ? IMG_W - 1 : IMG_W - 2);
  localparam logic [RW-1:0] WIN_ROW  = RW'((IMG_H % 2 == 0) ? IMG_H - 1 : IMG_H - 2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] prev_q;
  logic [PW-1:0] lb_q [IMG_W];
  logic          reg_valid_q;
  logic          frame_done_q;
  logic [CH*WW-1:0] reg_out_q;

  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] tl_idx;
  logic          lb_wr;
  logic          prev_wr;
  logic          win_fire;
  logic          last_win;
  logic [CH*WW-1:0] win;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    col_d = col_q;
    row_d = row_q;

    // A sof beat is pixel (0,0) whatever the counters say; this alone
    // discards any half-built window.
    cur_col = (c3_in_sof) ? '0 : col_q;
    cur_row = (c3_in_sof) ? '0 : row_q;

    lb_wr    = c3_in_valid & ~cur_row[0];
    prev_wr  = c3_in_valid &  cur_row[0] & ~cur_col[0];
    win_fire = c3_in_valid &  cur_row[0] &  cur_col[0];
    last_win = (cur_row == WIN_ROW) && (cur_col == WIN_COL);

    if (c3_in_valid) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end

    // cur_col is odd whenever the window is used, so col-1 stays in range.
    tl_idx = cur_col - 1'b1;
    win    = '0;
    for (int k = 0; k < CH; k++) begin
      win[k*WW +: WW] = {lb_q[tl_idx][k*DW +: DW],
                         lb_q[cur_col][k*DW +: DW],
                         prev_q[k*DW +: DW],
                         c3_in_data[k*DW +: DW]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      prev_q       <= '0;
      reg_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      reg_out_q    <= '0;
      // NOTE: the line buffer is deliberately reset as well so no window can
      // ever expose data from before the reset; it is small register storage,
      // not a RAM macro, so a reset loop is legal here.
      for (int i = 0; i < IMG_W; i++) begin
        lb_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      reg_valid_q  <= win_fire;
      frame_done_q <= win_fire & last_win;
      if (lb_wr) begin
        lb_q[cur_col] <= c3_in_data;
      end
      if (prev_wr) begin
        prev_q <= c3_in_data;
      end
      // Output word holds between pulses.
      if (win_fire) begin
        reg_out_q <= win;
      end
    end
  end

  assign c3_reg_valid  = reg_valid_q;
  assign c3_frame_done = frame_done_q;
  assign c3_reg_out    = reg_out_q;

endmodule

// File: tb/tb_c3_pool_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_c3_pool_window_buffer
//
// Directed sequence of frames (plain, channel-tagged, gapped, sof resync,
// mid-frame reset, back-to-back, random data). A reference model keeps the
// current frame as a 2-D pixel image and derives each expected window from
// the four neighbouring pixels; every clock the DUT outputs are compared with
// it, and each scenario adds fixed expected words and pulse counts.
// -----------------------------------------------------------------------------
module tb_c3_pool_window_buffer;

  localparam int IMG_W = 10;
  localparam int IMG_H = 10;
  localparam int CH    = 16;
  localparam int DW    = 8;
  localparam int PW    = CH * DW;
  localparam int WW    = 4 * DW;
  localparam int OW    = CH * WW;
  localparam int LWR   = (IMG_H % 2 == 0) ? IMG_H - 1 : IMG_H - 2;
  localparam int LWC   = (IMG_W % 2 == 0) ? IMG_W - 1 : IMG_W - 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          reg_valid;
  logic          frame_done;
  logic [OW-1:0] reg_out;

  c3_pool_window_buffer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CH    (CH),
    .DW    (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .c3_in_valid   (in_valid),
    .c3_in_sof     (in_sof),
    .c3_in_data    (in_data),
    .c3_reg_valid  (reg_valid),
    .c3_reg_out    (reg_out),
    .c3_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: image of the frame being received plus raster position.
  logic [PW-1:0] img [IMG_H][IMG_W];
  int            m_r;
  int            m_c;
  logic [OW-1:0] m_out;

  // Per-scenario observations.
  logic [OW-1:0] got [$];
  int            win_cnt;
  int            done_cnt;
  int            first_beat;
  int            beat_cnt;
  logic          last_done;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] rep_word(input logic [WW-1:0] w);
    logic [OW-1:0] r;
    for (int k = 0; k < CH; k++) r[k*WW +: WW] = w;
    return r;
  endfunction

  // mode 0: base + row*IMG_W + col on every channel
  // mode 1: {channel, col}
  // mode 2: random
  function automatic logic [PW-1:0] pix(input int mode, input int base, input int r, input int c);
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) begin
      case (mode)
        0:       p[k*DW +: DW] = DW'(base + r * IMG_W + c);
        1:       p[k*DW +: DW] = {4'(k), 4'(c)};
        default: p[k*DW +: DW] = DW'($urandom);
      endcase
    end
    return p;
  endfunction

  task automatic clear_stats();
    got.delete();
    win_cnt    = 0;
    done_cnt   = 0;
    first_beat = -1;
    beat_cnt   = 0;
    last_done  = 1'b0;
  endtask

  task automatic model_reset();
    m_r   = 0;
    m_c   = 0;
    m_out = '0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = '0;
  endtask

  // One clock: drive inputs, step the model, then compare after the edge.
  task automatic cycle(input logic v, input logic s, input logic [PW-1:0] d);
    logic exp_v;
    logic exp_d;
    exp_v    = 1'b0;
    exp_d    = 1'b0;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    if (v) begin
      if (s) begin
        m_r = 0;
        m_c = 0;
      end
      img[m_r][m_c] = d;
      if ((m_r % 2 == 1) && (m_c % 2 == 1)) begin
        exp_v = 1'b1;
        exp_d = (m_r == LWR) && (m_c == LWC);
        for (int k = 0; k < CH; k++) begin
          m_out[k*WW +: WW] = {img[m_r-1][m_c-1][k*DW +: DW],
                               img[m_r-1][m_c][k*DW +: DW],
                               img[m_r][m_c-1][k*DW +: DW],
                               d[k*DW +: DW]};
        end
      end
      m_c++;
      if (m_c == IMG_W) begin
        m_c = 0;
        m_r++;
        if (m_r == IMG_H) m_r = 0;
      end
      beat_cnt++;
    end
    @(posedge clk);
    #1;
    check("reg_valid",  OW'(reg_valid),  OW'(exp_v));
    check("frame_done", OW'(frame_done), OW'(exp_d));
    check("reg_out",    reg_out,         m_out);
    if (reg_valid === 1'b1) begin
      win_cnt++;
      if (win_cnt == 1) first_beat = beat_cnt;
      got.push_back(reg_out);
      last_done = frame_done;
    end
    if (frame_done === 1'b1) done_cnt++;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_valid", OW'(reg_valid),  '0);
      check("rst_done",  OW'(frame_done), '0);
      check("rst_out",   reg_out,         '0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  // Sends nbeats beats of a frame in raster order, with random idle cycles
  // (random data and sof on idle cycles, which must be ignored).
  task automatic send_frame(input int mode, input int base, input int gap_pct,
                            input logic sof_first, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      while (int'($urandom_range(99)) < gap_pct)
        cycle(1'b0, 1'($urandom), pix(2, 0, 0, 0));
      cycle(1'b1, sof_first && (i == 0), pix(mode, base, i / IMG_W, i % IMG_W));
    end
  endtask

  task automatic frame_summary(input string tag, input logic [WW-1:0] first_w,
                               input logic [WW-1:0] last_w);
    check({tag, "_windows"}, OW'(win_cnt), OW'(25));
    check({tag, "_done_cnt"}, OW'(done_cnt), OW'(1));
    if (got.size() > 0) begin
      check({tag, "_first"}, got[0], rep_word(first_w));
      check({tag, "_last"}, got[got.size()-1], rep_word(last_w));
      check({tag, "_last_done"}, OW'(last_done), OW'(1));
    end else begin
      check({tag, "_any_window"}, OW'(0), OW'(1));
    end
  endtask

  initial begin
    model_reset();
    clear_stats();

    // Reset state.
    apply_reset();

    // 1. Basic frame: first window right after beat 11 (12 beats seen).
    clear_stats();
    send_frame(0, 0, 0, 1'b1, IMG_W * IMG_H);
    frame_summary("t1", 32'h00010A0B, 32'h58596263);
    check("t1_first_latency", OW'(first_beat), OW'(12));

    // 2. Channel ordering.
    clear_stats();
    send_frame(1, 0, 0, 1'b1, IMG_W * IMG_H);
    check("t2_windows", OW'(win_cnt), OW'(25));
    if (got.size() > 0) begin
      check("t2_ch15", OW'(got[0][15*WW +: WW]), OW'(32'hF0F1F0F1));
      check("t2_ch0",  OW'(got[0][0 +: WW]),     OW'(32'h00010001));
      check("t2_ch7",  OW'(got[0][7*WW +: WW]),  OW'(32'h70717071));
    end else begin
      check("t2_any_window", OW'(0), OW'(1));
    end

    // 3. Gapped input.
    clear_stats();
    send_frame(0, 0, 40, 1'b1, IMG_W * IMG_H);
    frame_summary("t3", 32'h00010A0B, 32'h58596263);
    repeat (3) cycle(1'b0, 1'b0, pix(2, 0, 0, 0));

    // 4. SOF resync at beat 37 of a random-data frame.
    send_frame(2, 0, 0, 1'b1, 37);
    clear_stats();
    send_frame(0, 0, 0, 1'b1, IMG_W * IMG_H);
    frame_summary("t4", 32'h00010A0B, 32'h58596263);

    // 5. Reset after 53 beats, then a frame without sof.
    send_frame(2, 0, 0, 1'b1, 53);
    apply_reset();
    clear_stats();
    send_frame(0, 0, 0, 1'b0, IMG_W * IMG_H);
    frame_summary("t5", 32'h00010A0B, 32'h58596263);

    // 6. Back-to-back frames; the second relies on counter wrap (no sof).
    clear_stats();
    send_frame(0, 0,   0, 1'b1, IMG_W * IMG_H);
    send_frame(0, 100, 0, 1'b0, IMG_W * IMG_H);
    check("t6_windows", OW'(win_cnt), OW'(50));
    check("t6_done_cnt", OW'(done_cnt), OW'(2));
    if (got.size() > 25) check("t6_f2_first", got[25], rep_word(32'h64656E6F));
    else                 check("t6_f2_present", OW'(got.size()), OW'(50));

    // 7. Random data with gaps, two frames.
    clear_stats();
    send_frame(2, 0, 30, 1'b1, IMG_W * IMG_H);
    send_frame(2, 0, 30, 1'b0, IMG_W * IMG_H);
    check("t7_windows", OW'(win_cnt), OW'(50));
    check("t7_done_cnt", OW'(done_cnt), OW'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
